// File: rtl/cl_pkg.sv
// Shared opcode constants and sequencer state encodings for the bit-serial
// arbitrated logic engine.
package cl_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/cl.sv
// 1-bit logic unit: applies the selected opcode to a single bit pair.
module cl
   import cl_pkg::*;
(
   output logic       out,
   input  logic       a,
   input  logic       b,
   input  logic [1:0] s
);

   always_comb begin
      out = 1'b0;
      case (s)
         OP_AND:  out = a & b;
         OP_OR:   out = a | b;
         OP_XOR:  out = a ^ b;
         default: out = ~a;
      endcase
   end

endmodule

// File: rtl/cl_arb_seq.sv
// Two-requester round-robin arbiter feeding a bit-serial logic engine that
// processes one operand bit per cycle through a single shared 1-bit unit.
//
// state | meaning
// IDLE  | waiting for a request; grants combinationally and captures operands
// RUN   | one result bit per cycle, cnt = 0 .. W-1
// DONE  | one-cycle completion strobe to the owner, then back to IDLE
module cl_arb_seq
   import cl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] result,
   output logic         owner
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t          state_q, state_d;
   logic [1:0]      op_q;
   logic [W-1:0]    a_q, b_q, result_q;
   logic [CW-1:0]   cnt_q;
   logic            owner_q;
   logic            rr_q;      // requester favoured on a tie
   logic            grant;
   logic            sel;
   logic            bit_out;

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      sel     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant   = 1'b1;
               sel     = (req0 && req1) ? rr_q : req1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q == CW'(W - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= OP_AND;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         rr_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            op_q    <= sel ? op1 : op0;
            a_q     <= sel ? a1 : a0;
            b_q     <= sel ? b1 : b0;
            cnt_q   <= '0;
            owner_q <= sel;
            rr_q    <= ~sel;
         end
         if (state_q == RUN) begin
            result_q[cnt_q] <= bit_out;
            cnt_q           <= cnt_q + CW'(1);
         end
      end
   end

   cl u_cl (
      .out (bit_out),
      .a   (a_q[cnt_q]),
      .b   (b_q[cnt_q]),
      .s   (op_q)
   );

   assign gnt0   = grant & ~sel & reset_n;
   assign gnt1   = grant &  sel & reset_n;
   assign busy   = (state_q != IDLE);
   assign done0  = (state_q == DONE) & ~owner_q & reset_n;
   assign done1  = (state_q == DONE) &  owner_q & reset_n;
   assign result = result_q;
   assign owner  = owner_q;

endmodule
